// File: rtl/mem_responder.sv
// Memory-side responder for the MOV/MOC handshake. It adds programmable wait states and performs
// big-endian byte/halfword/word accesses into a byte array.
module mem_responder #(
  parameter int    ADDR_BITS   = 9,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mov,
  input  logic        rw,
  input  logic        sign,
  input  logic [1:0]  data_type,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   rw_q, rw_d, sign_q, sign_d;
  logic [1:0]             dt_q, dt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            dout_q, dout_d;
  logic                   err_q, err_d;

  logic [7:0]             mem_q [DEPTH];
  logic [ADDR_BITS-1:0]   a0, a1, a2, a3;
  logic [7:0]             b0, b1, b2, b3;
  logic                   bad;
  logic [31:0]            rdata;
  logic                   mem_we;
  logic                   unused_addr;

  assign unused_addr = ^address[31:ADDR_BITS];

  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_BITS'(1);
  assign a2 = addr_q + ADDR_BITS'(2);
  assign a3 = addr_q + ADDR_BITS'(3);
  assign b0 = mem_q[a0];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    bad   = 1'b0;
    rdata = {b0, b1, b2, b3};
    case (dt_q)
      2'b00: rdata = {{24{sign_q & b0[7]}}, b0};
      2'b01: begin
        bad   = addr_q[0];
        rdata = {{16{sign_q & b0[7]}}, b0, b1};
      end
      2'b10: bad = |addr_q[1:0];
      default: bad = 1'b1;
    endcase
  end

  assign mem_we = (state_q == S_ACCESS) && !rw_q && !bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (dt_q)
        2'b00: mem_q[a0] <= wdata_q[7:0];
        2'b01: begin
          mem_q[a0] <= wdata_q[15:8];
          mem_q[a1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[a0] <= wdata_q[31:24];
          mem_q[a1] <= wdata_q[23:16];
          mem_q[a2] <= wdata_q[15:8];
          mem_q[a3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  // WAIT always spans WAIT_CYCLES+1 cycles (exit at count 0) so moc rises N+WAIT_CYCLES+2
  // edges after capture, including the WAIT_CYCLES = 0 case.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    sign_d  = sign_q;
    dt_d    = dt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mov) begin
          rw_d    = rw;
          sign_d  = sign;
          dt_d    = data_type;
          addr_d  = address[ADDR_BITS-1:0];
          wdata_d = data_in;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mov) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        err_d   = bad;
        dout_d  = (rw_q && !bad) ? rdata : '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!mov) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      sign_q  <= 1'b0;
      dt_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      sign_q  <= sign_d;
      dt_q    <= dt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign data_out = dout_q;
  assign err      = err_q;
  assign moc      = (state_q == S_ACK);
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-array reference model predicts each response,
// a negedge monitor checks data, err and moc latency.
module tb_mem_responder;
    localparam int AB    = 9;
    localparam int WC    = 2;
    localparam int DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        mov = 1'b0, rw = 1'b0, sign = 1'b0;
    logic [1:0]  dt = 2'b00;
    logic [31:0] addr = '0, din = '0;
    logic [31:0] dout;
    logic        moc, err;

    logic        mov0 = 1'b0, rw0 = 1'b0, sign0 = 1'b0;
    logic [1:0]  dt0 = 2'b10;
    logic [31:0] addr0 = '0, din0 = '0;
    logic [31:0] dout0;
    logic        moc0, err0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
        .clk(clk), .clr(clr), .mov(mov), .rw(rw), .sign(sign), .data_type(dt),
        .address(addr), .data_in(din), .data_out(dout), .moc(moc), .err(err)
    );

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .clr(clr), .mov(mov0), .rw(rw0), .sign(sign0), .data_type(dt0),
        .address(addr0), .data_in(din0), .data_out(dout0), .moc(moc0), .err(err0)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] exp_data_q [$];
    logic        exp_err_q  [$];
    int          exp_cyc_q  [$];
    logic [31:0] cur_data = '0;
    logic        cur_err  = 1'b0;
    logic        moc_prev = 1'b0;
    logic [31:0] seen_data;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain byte-array arithmetic, n = 1/2/4 bytes, big-endian.
    task automatic model(input logic r, s, input logic [1:0] t, input logic [31:0] a, wd,
                         output logic [31:0] ed, output logic ee);
        int n;
        int base;
        logic [31:0] v;
        n    = 1 << t;
        base = int'(a % DEPTH);
        ee   = (t == 2'd3) || (t == 2'd1 && a[0]) || (t == 2'd2 && a[1:0] != 2'd0);
        ed   = '0;
        if (!ee) begin
            if (!r) begin
                for (int i = 0; i < n; i++)
                    ref_mem[(base + i) % DEPTH] = 8'(wd >> (8 * (n - 1 - i)));
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(base + i) % DEPTH]);
                if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                ed = v;
            end
        end
    endtask

    task automatic txn(input logic r, s, input logic [1:0] t, input logic [31:0] a, wd,
                       input int hold);
        logic [31:0] ed;
        logic ee;
        bit got;
        got = 1'b0;
        model(r, s, t, a, wd, ed, ee);
        rw = r; sign = s; dt = t; addr = a; din = wd; mov = 1'b1;
        exp_data_q.push_back(ed);
        exp_err_q.push_back(ee);
        exp_cyc_q.push_back(cyc + 1 + WC + 2);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            rw = 1'($urandom); sign = 1'($urandom); dt = 2'($urandom);
            addr = $urandom; din = $urandom;
            if (moc) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL moc_timeout: got moc=0, expected moc=1 within 40 cycles");
            void'(exp_data_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_cyc_q.pop_front());
        end
        seen_data = dout;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        mov = 1'b0;
        @(posedge clk); #1;
        chk("moc_fall", 32'(moc), 32'd0);
    endtask

    always @(negedge clk) begin
        if (clr && moc && !moc_prev) begin
            if (exp_data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_moc: got moc=1, expected no response");
            end else begin
                cur_data = exp_data_q.pop_front();
                cur_err  = exp_err_q.pop_front();
                chk("rsp_data", dout, cur_data);
                chk("rsp_err", 32'(err), 32'(cur_err));
                chk("rsp_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end else if (clr && moc) begin
            chk("ack_data_stable", dout, cur_data);
            chk("ack_err_stable", 32'(err), 32'(cur_err));
        end
        moc_prev = moc;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion, expected $finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_moc", 32'(moc), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_data", dout, 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH / 4; w++) txn(1'b0, 1'b0, 2'b10, 32'(w * 4), $urandom, 0);

        txn(1'b0, 1'b0, 2'b10, 32'h010, 32'hDEADBEEF, 0);
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 1);
        chk("word_read", seen_data, 32'hDEADBEEF);
        txn(1'b1, 1'b1, 2'b00, 32'h013, 32'h0, 0);
        chk("byte_sext", seen_data, 32'hFFFFFFEF);
        txn(1'b1, 1'b0, 2'b00, 32'h013, 32'h0, 0);
        chk("byte_zext", seen_data, 32'h000000EF);
        txn(1'b1, 1'b1, 2'b01, 32'h012, 32'h0, 0);
        chk("half_sext", seen_data, 32'hFFFFBEEF);
        txn(1'b1, 1'b1, 2'b00, 32'h011, 32'h0, 0);
        chk("byte1_sext", seen_data, 32'hFFFFFFAD);
        txn(1'b0, 1'b0, 2'b00, 32'h011, 32'hFFFFFF12, 0);
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 0);
        chk("byte_merge", seen_data, 32'hDE12BEEF);
        txn(1'b0, 1'b0, 2'b10, 32'h012, 32'h11223344, 0);
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 0);
        chk("misalign_no_write", seen_data, 32'hDE12BEEF);
        txn(1'b1, 1'b0, 2'b11, 32'h010, 32'h0, 0);
        txn(1'b1, 1'b0, 2'b01, 32'h011, 32'h0, 0);
        txn(1'b0, 1'b0, 2'b10, 32'h1FC, 32'hA5A55A5A, 0);
        txn(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0, 0);
        chk("last_word_wrap", seen_data, 32'hA5A55A5A);
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 5);

        // abort during WAIT: no moc, no write
        rw = 1'b0; dt = 2'b10; addr = 32'h010; din = 32'h0BADF00D; mov = 1'b1;
        @(posedge clk); #1;
        mov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_moc", 32'(moc), 32'd0);
        end
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 0);
        chk("abort_no_write", seen_data, 32'hDE12BEEF);

        // reset mid-WAIT of a byte write
        rw = 1'b0; dt = 2'b00; addr = 32'h010; din = 32'h55; mov = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("clr_moc", 32'(moc), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_data", dout, 32'd0);
        mov = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 2'b10, 32'h010, 32'h0, 0);
        chk("clr_no_write", seen_data, 32'hDE12BEEF);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            txn(1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                ra, $urandom, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // zero-wait instance: moc two edges after mov is sampled
        for (int p = 0; p < 2; p++) begin
            rw0 = (p == 1); dt0 = 2'b10; addr0 = 32'h020; din0 = 32'hCAFEF00D; mov0 = 1'b1;
            @(posedge clk); #1;
            chk("w0_moc_early1", 32'(moc0), 32'd0);
            @(posedge clk); #1;
            chk("w0_moc_early2", 32'(moc0), 32'd0);
            @(posedge clk); #1;
            chk("w0_moc", 32'(moc0), 32'd1);
            chk("w0_err", 32'(err0), 32'd0);
            chk("w0_data", dout0, (p == 1) ? 32'hCAFEF00D : 32'h0);
            mov0 = 1'b0;
            @(posedge clk); #1;
            chk("w0_moc_fall", 32'(moc0), 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
